// File: rtl/target_pkg.sv
// Shared types, constants and the nBits validity check for the target checker.
package target_pkg;

  localparam int unsigned TARGET_W       = 256;
  localparam int unsigned NBITS_EXP_BIAS = 3;
  localparam int unsigned MAX_EXP        = 32;
  localparam int unsigned EXP_W          = 8;
  localparam int unsigned MANT_W         = 24;
  localparam int unsigned WIDE_W         = TARGET_W + MANT_W;
  // |E-3| never exceeds 29 for an accepted exponent
  localparam int unsigned SHCNT_W        = 5;

  typedef enum logic [2:0] {
    IDLE,
    EXPAND,
    READY,
    COMPARE,
    DONE
  } state_e;

  typedef struct packed {
    logic [EXP_W-1:0]  e_val;
    logic [MANT_W-1:0] mant;
  } nbits_t;

  // Exponent too large, sign bit set, or mantissa pushed beyond the 256-bit target
  function automatic logic nbits_invalid(input nbits_t nb);
    logic [WIDE_W-1:0] wide;
    logic              bad;
    bad  = 1'b0;
    wide = '0;
    if (32'(nb.e_val) > MAX_EXP || nb.mant[MANT_W-1]) begin
      bad = 1'b1;
    end else if (32'(nb.e_val) > NBITS_EXP_BIAS && nb.mant != '0) begin
      wide = WIDE_W'(nb.mant) << (8 * (32'(nb.e_val) - NBITS_EXP_BIAS));
      bad  = |wide[WIDE_W-1:TARGET_W];
    end
    return bad;
  endfunction

endpackage

// File: rtl/target_expander.sv
// Byte shifter that expands a compact mantissa into the full 256-bit target.
module target_expander
  import target_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic                step_i,
  input  logic [EXP_W-1:0]    exp_i,
  input  logic [MANT_W-1:0]   mant_i,
  output logic [TARGET_W-1:0] target_o,
  output logic                done_o
);

  logic [TARGET_W-1:0] target_q, target_d;
  logic [SHCNT_W-1:0]  cnt_q, cnt_d;
  logic                left_q, left_d;

  // Load/clear the target, then shift one byte per step until the count is spent
  always_comb begin
    target_d = target_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    if (clear_i) begin
      target_d = '0;
      cnt_d    = '0;
    end else if (load_i) begin
      target_d = TARGET_W'(mant_i);
      left_d   = exp_i > EXP_W'(NBITS_EXP_BIAS);
      cnt_d    = left_d ? SHCNT_W'(exp_i - EXP_W'(NBITS_EXP_BIAS))
                        : SHCNT_W'(EXP_W'(NBITS_EXP_BIAS) - exp_i);
    end else if (step_i && cnt_q != '0) begin
      target_d = left_q ? (target_q << 8) : (target_q >> 8);
      cnt_d    = cnt_q - SHCNT_W'(1);
    end
  end

  // Expander state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      target_q <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
    end
  end

  assign target_o = target_q;
  assign done_o   = (cnt_q == '0);

endmodule

// File: rtl/target_check_ctrl.sv
// Target expansion and MSB-first word-serial hash <= target checker.
// Optional hit counters enabled by defining TARGET_CHECK_STATS_EN.
module target_check_ctrl
  import target_pkg::*;
#(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned NONCE_W = 32
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [31:0]         cfg_bits,
  output logic                tgt_valid,
  output logic                cfg_err,
  input  logic                hash_valid,
  output logic                hash_ready,
  input  logic [TARGET_W-1:0] hash_data,
  input  logic [NONCE_W-1:0]  hash_nonce,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_match,
`ifdef TARGET_CHECK_STATS_EN
  output logic [31:0]         stat_checked,
  output logic [31:0]         stat_matched,
`endif
  output logic [NONCE_W-1:0]  res_nonce
);

  localparam int unsigned NUM_WORDS = TARGET_W / WORD_W;
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_e              state_q, state_d;
  logic [TARGET_W-1:0] hash_q, hash_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tgt_valid_q, tgt_valid_d;
  logic                cfg_err_q, cfg_err_d;
  logic                res_match_q, res_match_d;
  logic [NONCE_W-1:0]  res_nonce_q, res_nonce_d;

  nbits_t              cfg_nb;
  logic                cfg_bad, cfg_fire, hash_fire, res_fire;
  logic [TARGET_W-1:0] target;
  logic                exp_done;
  logic [WORD_W-1:0]   hash_word, tgt_word;

  assign cfg_nb     = cfg_bits;
  assign cfg_bad    = nbits_invalid(cfg_nb);
  // A pending config always takes priority over a hash in READY
  assign cfg_ready  = (state_q == IDLE) || (state_q == READY);
  assign hash_ready = (state_q == READY) && !cfg_valid;
  assign res_valid  = (state_q == DONE);
  assign cfg_fire   = cfg_valid && cfg_ready;
  assign hash_fire  = hash_valid && hash_ready;
  assign res_fire   = res_valid && res_ready;

  assign hash_word  = hash_q[32'(idx_q) * WORD_W +: WORD_W];
  assign tgt_word   = target[32'(idx_q) * WORD_W +: WORD_W];

  target_expander u_expander (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .load_i   (cfg_fire && !cfg_bad),
    .clear_i  (cfg_fire && cfg_bad),
    .step_i   (state_q == EXPAND),
    .exp_i    (cfg_nb.e_val),
    .mant_i   (cfg_nb.mant),
    .target_o (target),
    .done_o   (exp_done)
  );

  // Sequencing FSM: config, expand, accept hash, compare, hand off result
  always_comb begin
    state_d     = state_q;
    hash_d      = hash_q;
    idx_d       = idx_q;
    tgt_valid_d = tgt_valid_q;
    cfg_err_d   = cfg_err_q;
    res_match_d = res_match_q;
    res_nonce_d = res_nonce_q;
    unique case (state_q)
      IDLE: state_d = IDLE;
      EXPAND: begin
        if (exp_done) begin
          tgt_valid_d = 1'b1;
          state_d     = READY;
        end
      end
      READY: begin
        if (hash_fire) begin
          hash_d      = hash_data;
          res_nonce_d = hash_nonce;
          idx_d       = IDX_W'(NUM_WORDS - 1);
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        if (hash_word < tgt_word) begin
          res_match_d = 1'b1;
          state_d     = DONE;
        end else if (hash_word > tgt_word) begin
          res_match_d = 1'b0;
          state_d     = DONE;
        end else if (idx_q == '0) begin
          res_match_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
    // Accepted config restarts expansion (or parks in IDLE when invalid)
    if (cfg_fire) begin
      tgt_valid_d = 1'b0;
      cfg_err_d   = cfg_bad;
      state_d     = cfg_bad ? IDLE : EXPAND;
    end
  end

  // FSM and result registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      hash_q      <= '0;
      idx_q       <= '0;
      tgt_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      res_match_q <= 1'b0;
      res_nonce_q <= '0;
    end else begin
      state_q     <= state_d;
      hash_q      <= hash_d;
      idx_q       <= idx_d;
      tgt_valid_q <= tgt_valid_d;
      cfg_err_q   <= cfg_err_d;
      res_match_q <= res_match_d;
      res_nonce_q <= res_nonce_d;
    end
  end

  assign tgt_valid = tgt_valid_q;
  assign cfg_err   = cfg_err_q;
  assign res_match = res_match_q;
  assign res_nonce = res_nonce_q;

`ifdef TARGET_CHECK_STATS_EN
  logic [31:0] checked_q, matched_q;

  // Result counters, restarted by every accepted config
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || cfg_fire) begin
      checked_q <= '0;
      matched_q <= '0;
    end else if (res_fire) begin
      checked_q <= checked_q + 32'd1;
      if (res_match_q) matched_q <= matched_q + 32'd1;
    end
  end

  assign stat_checked = checked_q;
  assign stat_matched = matched_q;
`else
  logic unused_res_fire;
  assign unused_res_fire = res_fire;
`endif

endmodule

// File: tb/tb_target_check_ctrl.sv
// Scoreboard bench for target_check_ctrl with a behavioural target/compare model.
`timescale 1ns/1ps
module tb_target_check_ctrl;

  localparam int NW = 8;

  logic         clk = 1'b0;
  logic         wb_rst_i;
  logic         cfg_valid, cfg_ready, tgt_valid, cfg_err;
  logic [31:0]  cfg_bits;
  logic         hash_valid, hash_ready;
  logic [255:0] hash_data;
  logic [31:0]  hash_nonce;
  logic         res_valid, res_ready, res_match;
  logic [31:0]  res_nonce;
`ifdef TARGET_CHECK_STATS_EN
  logic [31:0]  stat_checked, stat_matched;
`endif

  always #5 clk = ~clk;

  target_check_ctrl #(.WORD_W(32), .NONCE_W(32)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_bits   (cfg_bits),
    .tgt_valid  (tgt_valid),
    .cfg_err    (cfg_err),
    .hash_valid (hash_valid),
    .hash_ready (hash_ready),
    .hash_data  (hash_data),
    .hash_nonce (hash_nonce),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_match  (res_match),
`ifdef TARGET_CHECK_STATS_EN
    .stat_checked (stat_checked),
    .stat_matched (stat_matched),
`endif
    .res_nonce  (res_nonce)
  );

  typedef struct {
    logic        match;
    logic [31:0] nonce;
    int          lat;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           hold_res = 1'b0;
  logic [255:0] cur_tgt = '0;
  bit           tgt_ok = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Reference: nBits -> integer target
  function automatic logic [255:0] m_target(input logic [31:0] b);
    int           e;
    logic [255:0] m;
    e = int'(b[31:24]);
    m = 256'(b[23:0]);
    if (e <= 3) return m >> (8 * (3 - e));
    return m << (8 * (e - 3));
  endfunction

  function automatic bit m_invalid(input logic [31:0] b);
    int e;
    e = int'(b[31:24]);
    if (e > 32 || b[23]) return 1'b1;
    if (e > 3 && b[23:0] != 24'd0 && (m_target(b) >> (8 * (e - 3))) != 256'(b[23:0])) return 1'b1;
    return 1'b0;
  endfunction

  // Compare cycles = words scanned from the top until the first difference
  function automatic int m_lat(input logic [255:0] h, input logic [255:0] t);
    logic [255:0] x;
    x = h ^ t;
    for (int p = 255; p >= 0; p--) if (x[p]) return NW - p / 32;
    return NW;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Downstream readiness
  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      res_ready = hold_res ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  // Monitor: latency, hold stability and scoreboard pops
  initial begin : mon
    int          cyc;
    int          hs_cyc;
    bit          pv, pr;
    logic        pm;
    logic [31:0] pn;
    exp_t        e;
    cyc = 0; hs_cyc = 0; pv = 1'b0; pr = 1'b0; pm = 1'b0; pn = '0;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (wb_rst_i) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("res_hold_valid", 64'(res_valid), 64'(1));
          check("res_hold_match", 64'(res_match), 64'(pm));
          check("res_hold_nonce", 64'(res_nonce), 64'(pn));
        end else if (res_valid && !pv) begin
          if (sb.size() == 0) fail("res_unexpected");
          else check("res_latency", 64'(cyc - hs_cyc - 1), 64'(sb[0].lat));
        end
        if (res_valid && res_ready) begin
          if (sb.size() == 0) fail("res_no_expect");
          else begin
            e = sb.pop_front();
            check("res_match", 64'(res_match), 64'(e.match));
            check("res_nonce", 64'(res_nonce), 64'(e.nonce));
          end
        end
        if (hash_valid && hash_ready) hs_cyc = cyc;
        pv = res_valid; pr = res_ready; pm = res_match; pn = res_nonce;
      end
    end
  end

  // Post-handshake checks for a config; handshake edge just passed
  task automatic after_cfg(input logic [31:0] bits);
    int lat;
    int e;
    e = int'(bits[31:24]);
    check("cfg_tgt_cleared", 64'(tgt_valid), 64'(0));
    if (m_invalid(bits)) begin
      check("cfg_err_set", 64'(cfg_err), 64'(1));
      check("cfg_idle_cfg_ready", 64'(cfg_ready), 64'(1));
      check("cfg_idle_hash_ready", 64'(hash_ready), 64'(0));
      tgt_ok = 1'b0;
    end else begin
      check("cfg_err_clr", 64'(cfg_err), 64'(0));
      lat = 0;
      while (!tgt_valid && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      check("cfg_latency", 64'(lat), 64'((e > 3) ? (e - 3 + 1) : (3 - e + 1)));
      cur_tgt = m_target(bits);
      tgt_ok  = 1'b1;
    end
  endtask

  task automatic do_cfg(input logic [31:0] bits);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cfg_ready && guard < 400) begin
      guard++;
      @(negedge clk);
    end
    if (!cfg_ready) begin
      fail("cfg_ready_timeout");
    end else begin
      cfg_bits  = bits;
      cfg_valid = 1'b1;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      after_cfg(bits);
    end
  endtask

  task automatic do_hash(input logic [255:0] h, input logic [31:0] n);
    exp_t e;
    int   guard;
    bit   got;
    guard = 0;
    got   = 1'b0;
    while (!got && guard < 400) begin
      @(negedge clk);
      hash_data  = h;
      hash_nonce = n;
      hash_valid = 1'b1;
      #1;
      if (hash_ready) got = 1'b1;
      else guard++;
    end
    if (!got) begin
      hash_valid = 1'b0;
      fail("hash_ready_timeout");
    end else begin
      e.match = (h <= cur_tgt);
      e.nonce = n;
      e.lat   = m_lat(h, cur_tgt);
      sb.push_back(e);
      @(posedge clk); #1;
      hash_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 600) begin
      guard++;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      fail("drain_timeout");
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_hash(input logic [31:0] n);
    logic [255:0] h;
    int           w;
    h = cur_tgt;
    case ($urandom_range(5))
      0: h = rnd256();
      1: h = cur_tgt;
      2: begin w = $urandom_range(7); h[w*32 +: 32] = $urandom; end
      3: h = cur_tgt + 256'd1;
      4: h = (cur_tgt != '0) ? cur_tgt - 256'd1 : '0;
      default: h = rnd256() >> $urandom_range(255);
    endcase
    do_hash(h, n);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] b;
    wb_rst_i = 1'b1; cfg_valid = 1'b0; cfg_bits = '0;
    hash_valid = 1'b0; hash_data = '0; hash_nonce = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", 64'(cfg_ready), 64'(1));
    check("rst_hash_ready", 64'(hash_ready), 64'(0));
    check("rst_tgt_valid", 64'(tgt_valid), 64'(0));
    check("rst_cfg_err", 64'(cfg_err), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    @(negedge clk);
    wb_rst_i = 1'b0;

    // Mainnet-style target and boundary hashes
    do_cfg(32'h1d00ffff);
    do_hash(cur_tgt, 32'h42);
    do_hash(cur_tgt + 256'd1, 32'h43);
    do_hash(256'hffff << 240, 32'h44);
    do_hash(256'd0, 32'h45);
    for (int i = 0; i < 30; i++) rand_hash(32'h100 + 32'(i));
    drain();

    // Right-shifting exponent
    do_cfg(32'h01123456);
    do_hash(256'h12, 32'h51);
    do_hash(256'h13, 32'h52);
    do_hash(256'h11, 32'h53);
    drain();

    // Invalid configs
    do_cfg(32'h21000001);
    do_cfg(32'h03800000);

    // cfg and hash offered together in READY: cfg wins
    do_cfg(32'h03123456);
    @(negedge clk);
    cfg_bits = 32'h04001234; cfg_valid = 1'b1;
    hash_data = '0; hash_nonce = 32'h99; hash_valid = 1'b1;
    #1;
    check("both_hash_ready", 64'(hash_ready), 64'(0));
    check("both_cfg_ready", 64'(cfg_ready), 64'(1));
    @(posedge clk); #1;
    cfg_valid = 1'b0; hash_valid = 1'b0;
    after_cfg(32'h04001234);

    // Downstream stall: result held, no new hash taken
    hold_res = 1'b1;
    @(negedge clk);
    do_hash(cur_tgt - 256'd5, 32'h77);
    begin
      int guard;
      guard = 0;
      while (!res_valid && guard < 50) begin guard++; @(posedge clk); #1; end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hash_data = rnd256(); hash_nonce = 32'hdead; hash_valid = 1'b1;
      #1;
      check("stall_hash_ready", 64'(hash_ready), 64'(0));
      check("stall_res_valid", 64'(res_valid), 64'(1));
    end
    hash_valid = 1'b0;
    hold_res = 1'b0;
    drain();

    // Randomised configs, each followed by a few hashes
    for (int c = 0; c < 14; c++) begin
      b[31:24] = 8'($urandom_range(33));
      b[23:0]  = 24'($urandom) & 24'h7fffff;
      if ($urandom_range(7) == 0) b[23] = 1'b1;
      do_cfg(b);
      if (tgt_ok) begin
        for (int i = 0; i < 5; i++) rand_hash($urandom);
        drain();
      end
    end

`ifdef TARGET_CHECK_STATS_EN
    do_cfg(32'h1d00ffff);
    check("stat_chk_clr", 64'(stat_checked), 64'(0));
    check("stat_mat_clr", 64'(stat_matched), 64'(0));
    do_hash(cur_tgt, 32'h1);
    do_hash(cur_tgt + 256'd1, 32'h2);
    do_hash(rnd256() | (256'd1 << 255), 32'h3);
    drain();
    check("stat_checked", 64'(stat_checked), 64'(3));
    check("stat_matched", 64'(stat_matched), 64'(1));
    do_cfg(32'h03000001);
    check("stat_chk_cfg", 64'(stat_checked), 64'(0));
    check("stat_mat_cfg", 64'(stat_matched), 64'(0));
`endif

    // Reset in the middle of a compare abandons it
    do_cfg(32'h1d00ffff);
    do_hash(cur_tgt, 32'h0000_0077);
    drain();
    do_hash(cur_tgt, 32'h0000_0088);
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    check("mid_rst_cfg_ready", 64'(cfg_ready), 64'(1));
    check("mid_rst_hash_ready", 64'(hash_ready), 64'(0));
    check("mid_rst_tgt_valid", 64'(tgt_valid), 64'(0));
    check("mid_rst_cfg_err", 64'(cfg_err), 64'(0));
    check("mid_rst_res_valid", 64'(res_valid), 64'(0));
    check("mid_rst_res_match", 64'(res_match), 64'(0));
    check("mid_rst_res_nonce", 64'(res_nonce), 64'(0));
    @(negedge clk);
    wb_rst_i = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("post_rst_res_valid", 64'(res_valid), 64'(0));
    check("post_rst_hash_ready", 64'(hash_ready), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
